alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit alu_ctrl code from decode, plus two operands.
//  Valid/ready handshake on both sides. Shifts are serial (1 bit/cycle); all other ops take 1 cycle.
//  Sits between decode/alu-control and writeback; lets the core run without a barrel shifter.
// PARAMETERS
//  XLEN     32  operand/result width
//  SHAMT_W  5   shift-amount width, = clog2(XLEN); shamt = op_b[SHAMT_W-1:0]
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operation offered
//  in_ready   out  1     block accepts operation this cycle
//  alu_ctrl   in   4     `ALU_* code from defines.vh
//  op_a       in   XLEN  operand A
//  op_b       in   XLEN  operand B
//  out_valid  out  1     result available
//  out_ready  in   1     consumer takes result this cycle
//  result     out  XLEN  registered result
//  zero       out  1     registered (result == 0)
//  busy       out  1     serial shift in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, zero=0, busy=0, shift counter=0.
//  rst mid-shift aborts the op; it produces no output.
//  Accept when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Back-to-back single-cycle ops sustain 1 op/cycle.
//  FSM: IDLE -> SHIFT when a shift is accepted with shamt!=0; SHIFT -> IDLE when the count hits 0.
//  Non-shift ops and shamt==0 shifts stay in IDLE; result is registered with latency 1.
//  Ops (XLEN wrap, carries dropped):
//   - ADD/SUB: a+b / a-b.
//   - AND/OR/XOR: bitwise.
//   - SLT: signed a<b -> 1 else 0, zero-extended.
//   - SLTU: unsigned compare, same encoding as SLT.
//   - SLL/SRL/SRA: shift by shamt; SRA replicates a[XLEN-1].
//   - Unlisted codes behave as ADD.
//  SHIFT state:
//   - Working register loaded with op_a; counter loaded with shamt; busy=1.
//   - Each cycle: shift 1 bit, decrement counter.
//   - When the counter reaches 0: result<=working reg, out_valid<=1, busy<=0, return to IDLE.
//   - Total latency shamt+1 cycles; in_ready=0 throughout; in_valid is ignored.
//  Output hold: while out_valid && !out_ready, result and zero stay stable.
//  Same-cycle pop and accept: the new result replaces the old one next cycle, out_valid stays 1.
//  Pop without accept: out_valid<=0.
//  The output slot is always free at shift completion; shifts are accepted only when it is free or draining.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined:
//   - Shifts use a combinational barrel shifter with latency 1; SHIFT state is not built.
//   - busy is tied 0.
//  ALU_FAST_SHIFT_EN undefined: serial shifting as above (default).
// STRUCTURE
//  `ALU_ADD..`ALU_AND codes live in shared defines.vh, already used by decode; no local copies.
//  FSM state encodings are local localparams.
//  Sub-module alu_serial_shifter:
//   - Contains the working register, down-counter and direction/arith control.
//   - Interface: start, shamt, dir, arith, din -> done, dout.
//   - Omitted under ALU_FAST_SHIFT_EN.
//  Top level holds the handshake, the 1-cycle datapath mux and the output register.
// TESTING
//  1. ADD a=32'h7FFF_FFFF b=1, out_ready=1 -> next cycle result=32'h8000_0000, zero=0, out_valid=1.
//  2. SUB a=5 b=5 -> result=0, zero=1; SLT a=32'hFFFF_FFFF b=1 -> 1; SLTU same operands -> 0.
//  3. SRA a=32'h8000_0000 shamt=4 -> in_ready low 4 cycles, busy=1; out_valid on cycle 5; result=32'hF800_0000.
//  4. SLL a=1 shamt=0 -> result=1 after 1 cycle; SRL a=32'h8000_0000 shamt=31 -> 1 after 32 cycles.
//  5. Backpressure: out_ready=0 for 3 cycles after XOR 32'hF0F0^32'h0FF0 -> result holds 32'hFF00, in_ready=0;
//     out_ready=1 with a new op in the same cycle -> next result follows without a bubble.
//  6. rst asserted on the 2nd cycle of SLL shamt=10 -> following cycle out_valid=0, busy=0, in_ready=1.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// Shared ALU control codes and helpers used by decode and the execute stage.
// Code order follows the decode table: ALU_ADD first, ALU_AND last.
package alu_seq_exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: loads din/shamt on start, then shifts until the count drains.
// done is high in the cycle whose edge produces the final value on dout.
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    input  logic [XLEN-1:0]    din,
    output logic               done,
    output logic [XLEN-1:0]    dout
);

    logic [XLEN-1:0]    work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_q;
    logic               arith_q;
    logic               fill;

    // dir_q=1 shifts right; arithmetic right shifts refill with the sign bit.
    always_comb begin
        fill = arith_q & work_q[XLEN-1];
        dout = dir_q ? {fill, work_q[XLEN-1:1]} : {work_q[XLEN-2:0], 1'b0};
        done = (cnt_q == SHAMT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            work_q  <= din;
            cnt_q   <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (cnt_q != '0) begin
            work_q <= dout;
            cnt_q  <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready on both sides; shifts run serially unless
// ALU_FAST_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid holds its payload until then, ready may change freely.
    logic               accept;
    logic               go_serial;
    logic               shift_fin;
    logic [XLEN-1:0]    shift_dout;
    logic [XLEN-1:0]    fast_res;
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = op_b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        fast_res = op_a + op_b;
        case (alu_ctrl)
            ALU_SUB:  fast_res = op_a - op_b;
            ALU_AND:  fast_res = op_a & op_b;
            ALU_OR:   fast_res = op_a | op_b;
            ALU_XOR:  fast_res = op_a ^ op_b;
            ALU_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: fast_res = {{(XLEN-1){1'b0}}, op_a < op_b};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  fast_res = op_a << shamt;
            ALU_SRL:  fast_res = op_a >> shamt;
            ALU_SRA:  fast_res = XLEN'($signed(op_a) >>> shamt);
`else
            // Only shamt==0 shifts take the single-cycle path here.
            ALU_SLL, ALU_SRL, ALU_SRA: fast_res = op_a;
`endif
            default:  fast_res = op_a + op_b;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign go_serial  = 1'b0;
    assign shift_fin  = 1'b0;
    assign shift_dout = '0;
    assign busy       = 1'b0;
    assign in_ready   = !out_valid || out_ready;
`else
    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SHIFT = 1'b1;

    logic state_q;
    logic state_d;
    logic shift_done;

    assign go_serial = accept && is_shift(alu_ctrl) && (shamt != '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= STATE_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE:  if (go_serial)  state_d = STATE_SHIFT;
            STATE_SHIFT: if (shift_done) state_d = STATE_IDLE;
            default:     state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == STATE_SHIFT);
        in_ready  = (state_q == STATE_IDLE) && (!out_valid || out_ready);
        shift_fin = busy && shift_done;
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (go_serial),
        .shamt (shamt),
        .dir   (alu_ctrl != ALU_SLL),
        .arith (alu_ctrl == ALU_SRA),
        .din   (op_a),
        .done  (shift_done),
        .dout  (shift_dout)
    );
`endif

    // The slot is always empty at shift completion, so that branch never overwrites a live result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (shift_fin) begin
            out_valid <= 1'b1;
            result    <= shift_dout;
            zero      <= (shift_dout == '0);
        end else if (accept && !go_serial) begin
            out_valid <= 1'b1;
            result    <= fast_res;
            zero      <= (fast_res == '0);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec (default serial-shift build).
module tb_alu_seq_exec;
    import alu_seq_exec_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    alu_seq_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'($signed(a) >>> sh);
            default:  return a + b;
        endcase
    endfunction

    // scoreboard: every output transfer pops one expectation
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result=%h with empty queue", result);
            end else begin
                e = exp_q.pop_front();
                if (result !== e || zero !== (e == 32'd0)) begin
                    errors++;
                    $display("FAIL scoreboard: got result=%h zero=%b, expected result=%h zero=%b",
                             result, zero, e, (e == 32'd0));
                end
            end
        end
    end

    // driver: offer one op, wait for acceptance, push its expectation
    task automatic drive_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ctrl=%0d in_ready=%b, expected 1 within 100 cycles", c, in_ready);
        end else begin
            exp_q.push_back(model(c, a, b));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b result=%h zero=%b busy=%b, expected 0 0 0 0",
                     out_valid, result, zero, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        drive_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: out_valid=%b result=%h zero=%b, expected 1 80000000 0",
                     out_valid, result, zero);
        end
        drive_op(ALU_SUB, 32'd5, 32'd5);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: result=%h zero=%b, expected 00000000 1", result, zero);
        end
        drive_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (result !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed: result=%h, expected 00000001", result);
        end
        drive_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL sltu_unsigned: result=%h, expected 00000000", result);
        end
        drive_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive_op(ALU_OR,  32'hF000_0001, 32'h0000_F002);
        drive_op(4'd13,   32'd40, 32'd2);
        wait_drain();
    endtask

    task automatic test_shift_serial();
        drive_op(ALU_SRA, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL sra_busy[%0d]: in_ready=%b busy=%b out_valid=%b, expected 0 1 0",
                         i, in_ready, busy, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hF800_0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sra_done: out_valid=%b result=%h busy=%b, expected 1 f8000000 0",
                     out_valid, result, busy);
        end
        @(posedge clk);
        #1;
        drive_op(ALU_SLL, 32'd1, 32'd0);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sll_shamt0: out_valid=%b result=%h busy=%b, expected 1 00000001 0",
                     out_valid, result, busy);
        end
        begin
            int edges = 1;
            drive_op(ALU_SRL, 32'h8000_0000, 32'd31);
            while (out_valid !== 1'b1 && edges < 100) begin
                @(posedge clk);
                #1;
                edges++;
            end
            checks++;
            if (edges != 32 || result !== 32'd1) begin
                errors++;
                $display("FAIL srl_31_latency: edges=%0d result=%h, expected 32 00000001", edges, result);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_op(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h0000_FF00 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b, expected 1 0000ff00 0",
                         i, out_valid, result, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive_op(ALU_SUB, 32'd100, 32'd1);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd99) begin
            errors++;
            $display("FAIL pop_and_accept: out_valid=%b result=%h, expected 1 00000063", out_valid, result);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[8];
        int start_cyc;
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, 4'd15};
        start_cyc = cyc;
        for (int i = 0; i < 8; i++)
            drive_op(ops[i], $urandom, $urandom);
        checks++;
        if (cyc - start_cyc != 8) begin
            errors++;
            $display("FAIL back_to_back_rate: %0d cycles for 8 ops, expected 8", cyc - start_cyc);
        end
        wait_drain();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (is_shift(c)) drive_op(c, $urandom, 32'($urandom_range(0, 7)));
            else             drive_op(c, $urandom, $urandom);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_shift();
        drive_op(ALU_SLL, 32'd1, 32'd10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: out_valid=%b busy=%b in_ready=%b, expected 0 0 1",
                     out_valid, busy, in_ready);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL aborted_output: out_valid=%b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        drive_op(ALU_ADD, 32'd3, 32'd4);
        wait_drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = ALU_ADD;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        test_reset();
        test_arith();
        test_shift_serial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
